// File: rtl/pwr_pkg.sv
// Shared types and defaults for the pulse-width responder slice.
// Optional MEAS timeout is enabled with the PWR_TIMEOUT_EN macro (see pulse_width_responder).
package pwr_pkg;

  localparam int W_DEF   = 8;
  localparam int TMO_DEF = 255;

  // Saturation value of a default-width counter.
  localparam logic [W_DEF-1:0] MAX = {W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    MEAS = 2'd2
  } pwr_state_e;

endpackage

// File: rtl/pulse_width_counter.sv
// Measures high-pulse widths on 'in'; 'done' strobes for one cycle on the falling
// edge of a pulse whose rising edge was seen after reset, with 'width' valid alongside.
module pulse_width_counter
  import pwr_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  output logic         done,
  output logic [W-1:0] width
);

  localparam logic [W-1:0] SAT = {W{1'b1}};

  logic         in_q;
  logic [W-1:0] count;

  // count==0 while high marks a pulse that was already high at reset release:
  // it never increments and its falling edge produces no strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q  <= 1'b1;
      count <= '0;
    end else begin
      in_q <= in;
      if (!in) begin
        count <= '0;
      end else if (!in_q) begin
        count <= W'(1);
      end else if ((count != '0) && (count != SAT)) begin
        count <= count + 1'b1;
      end
    end
  end

  assign done  = in_q && !in && (count != '0);
  assign width = count;

endmodule

// File: rtl/pulse_width_responder.sv
// soc/eoc responder returning one fresh pulse-width measurement per handshake.
// Define PWR_TIMEOUT_EN to abort MEAS with numero=0 after TMO cycles without a completion.
module pulse_width_responder
  import pwr_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in,
  input  logic         soc,
  output logic         eoc,
  output logic [W-1:0] numero,
  output pwr_state_e   state_dbg
);

  // Handshake: initiator raises soc only while eoc==1; eoc falls the cycle after
  // soc is sampled high, the initiator drops soc, and eoc rises again (with numero
  // valid and held) only after soc was seen low and a pulse completed in MEAS.

  if ((TMO < 1) || (TMO > (2 ** W) - 1)) begin : g_tmo_range
    $error("pulse_width_responder: TMO must be in 1 .. 2**W-1");
  end

  pwr_state_e   state, state_n;
  logic         eoc_n;
  logic [W-1:0] numero_n;
  logic         done;
  logic [W-1:0] width;

  pulse_width_counter #(.W(W)) u_counter (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .done  (done),
    .width (width)
  );

`ifdef PWR_TIMEOUT_EN
  localparam logic [W-1:0] TMO_LAST = W'(TMO - 1);

  logic [W-1:0] timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if ((state == ACK) && !soc) begin
      timer <= '0;
    end else if (state == MEAS) begin
      timer <= timer + 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      eoc    <= 1'b1;
      numero <= '0;
    end else begin
      state  <= state_n;
      eoc    <= eoc_n;
      numero <= numero_n;
    end
  end

  always_comb begin
    state_n  = state;
    eoc_n    = eoc;
    numero_n = numero;
    case (state)
      IDLE: begin
        if (soc) begin
          eoc_n   = 1'b0;
          state_n = ACK;
        end
      end
      ACK: begin
        if (!soc) begin
          state_n = MEAS;
        end
      end
      MEAS: begin
        // A completion on the timeout cycle takes priority over the abort.
        if (done) begin
          numero_n = width;
          eoc_n    = 1'b1;
          state_n  = IDLE;
        end
`ifdef PWR_TIMEOUT_EN
        else if (timer == TMO_LAST) begin
          numero_n = '0;
          eoc_n    = 1'b1;
          state_n  = IDLE;
        end
`endif
      end
      default: begin
        eoc_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pulse_width_responder.sv
// Bench for pulse_width_responder: directed table, hand-written corner sequences,
// and randomized handshakes checked against a timestamp-based reference model.
module tb_pulse_width_responder;
  import pwr_pkg::*;

  localparam int W    = 8;
  localparam int TMO  = 10;
  localparam int MAXV = (2 ** W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in    = 1'b0;
  logic         soc   = 1'b0;
  logic         eoc;
  logic [W-1:0] numero;
  pwr_state_e   state_dbg;

  always #5 clock = ~clock;

  pulse_width_responder #(.W(W), .TMO(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .in        (in),
    .soc       (soc),
    .eoc       (eoc),
    .numero    (numero),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Completions are timestamped: a pulse rising at edge r and falling at edge f
  // has width min(f-r, MAXV). A request becomes measurable from the edge after
  // soc is seen low; the first completion from then on is the result.
  int           cyc_n = 0;
  bit           m_prev_in;
  bit           m_rise_valid;
  int           m_rise_n;
  bit           m_busy;
  int           m_meas_from;
  logic [W-1:0] m_numero;
  logic [W-1:0] exp_q[$];
  logic         eoc_prev;

  task automatic model_reset();
    m_prev_in    = 1'b1;
    m_rise_valid = 1'b0;
    m_rise_n     = 0;
    m_busy       = 1'b0;
    m_meas_from  = -1;
    m_numero     = '0;
    exp_q.delete();
    eoc_prev     = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic i, input logic s);
    bit comp;
    int wid;
    in  = i;
    soc = s;
    @(posedge clock);
    cyc_n++;
    comp = m_prev_in && !i && m_rise_valid;
    wid  = cyc_n - m_rise_n;
    if (wid > MAXV) wid = MAXV;
    if (!m_prev_in && i) begin
      m_rise_valid = 1'b1;
      m_rise_n     = cyc_n;
    end else if (!i) begin
      m_rise_valid = 1'b0;
    end
    m_prev_in = i;

    if (!m_busy) begin
      if (s) begin
        m_busy      = 1'b1;
        m_meas_from = -1;
      end
    end else if (m_meas_from < 0) begin
      if (!s) m_meas_from = cyc_n + 1;
    end else begin
      if (comp) begin
        m_numero = wid[W-1:0];
        m_busy   = 1'b0;
        exp_q.push_back(wid[W-1:0]);
      end
`ifdef PWR_TIMEOUT_EN
      else if (cyc_n - m_meas_from == TMO - 1) begin
        m_numero = '0;
        m_busy   = 1'b0;
        exp_q.push_back('0);
      end
`endif
    end

    #1;
    check("model_eoc", eoc, !m_busy);
    check("model_numero", numero, m_numero);
    if (eoc && !eoc_prev) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL scoreboard: eoc rose with numero=%0d, expected no result", numero);
      end else begin
        check("scoreboard", numero, exp_q.pop_front());
      end
    end
    eoc_prev = eoc;
  endtask

  task automatic do_reset(input logic in_v);
    reset = 1'b1;
    in    = in_v;
    soc   = 1'b0;
    #1;
    check("reset_eoc", eoc, 1'b1);
    check("reset_numero", numero, '0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic         in;
    logic         soc;
    logic         eoc;
    logic [W-1:0] num;
  } vec_t;

  vec_t t1[9];

  task automatic run_table(input string tag);
    for (int k = 0; k < 9; k++) begin
      cyc(t1[k].in, t1[k].soc);
      check({tag, "_eoc"}, eoc, t1[k].eoc);
      check({tag, "_numero"}, numero, t1[k].num);
    end
  endtask

  logic rin = 1'b0;

  task automatic rand_in();
    if ($urandom_range(0, 2) == 0) rin = ~rin;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idle_n;
    int hold_n;
    int guard;

    t1[0] = '{1'b0, 1'b1, 1'b0, 8'd0};
    t1[1] = '{1'b0, 1'b0, 1'b0, 8'd0};
    t1[2] = '{1'b1, 1'b0, 1'b0, 8'd0};
    t1[3] = '{1'b1, 1'b0, 1'b0, 8'd0};
    t1[4] = '{1'b1, 1'b0, 1'b0, 8'd0};
    t1[5] = '{1'b1, 1'b0, 1'b0, 8'd0};
    t1[6] = '{1'b1, 1'b0, 1'b0, 8'd0};
    t1[7] = '{1'b0, 1'b0, 1'b1, 8'd5};
    t1[8] = '{1'b0, 1'b0, 1'b1, 8'd5};

    #2;
    do_reset(1'b0);

    // 1: basic handshake with a 5-cycle pulse
    run_table("t1");

    // 2: 3-cycle pulse completing in ACK is ignored, 7-cycle pulse in MEAS returned
    cyc(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    check("t2_busy_after_ack_pulse", eoc, 1'b0);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("t2_eoc", eoc, 1'b1);
    check("t2_numero", numero, 8'd7);

    // 3: 300-cycle pulse saturates
    for (int k = 0; k < 295; k++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    check("t3_busy", eoc, 1'b0);
    cyc(1'b0, 1'b0);
    check("t3_eoc", eoc, 1'b1);
    check("t3_numero", numero, 8'd255);

    // 4: pulse high across reset release is not measured
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("t4_masked_fall", eoc, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("t4_eoc", eoc, 1'b1);
    check("t4_numero", numero, 8'd2);

    // 5: reset in MEAS mid-pulse, then a clean handshake
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    check("t5_busy", eoc, 1'b0);
    do_reset(1'b0);
    run_table("t5");

    // 6: no pulse in MEAS
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b0);
    check("t6_busy_before_tmo", eoc, 1'b0);
    cyc(1'b0, 1'b0);
`ifdef PWR_TIMEOUT_EN
    check("t6_eoc", eoc, 1'b1);
    check("t6_numero", numero, 8'd0);
`else
    check("t6_eoc", eoc, 1'b0);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0);
    check("t6_eoc_late", eoc, 1'b0);
`endif
    do_reset(1'b0);

    // randomized handshakes against the model
    for (int k = 0; k < 40; k++) begin
      idle_n = $urandom_range(0, 3);
      hold_n = $urandom_range(1, 3);
      for (int j = 0; j < idle_n; j++) begin
        rand_in();
        cyc(rin, 1'b0);
      end
      for (int j = 0; j < hold_n; j++) begin
        rand_in();
        cyc(rin, 1'b1);
      end
      guard = 0;
      while (m_busy && (guard < 200)) begin
        rand_in();
        cyc(rin, 1'b0);
        guard++;
      end
      if (m_busy) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rand_budget: transaction %0d still busy after %0d cycles", k, guard);
        do_reset(1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
